alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_iter.sv | 75 +++++++
 rtl/alu_pipe.sv | 134 +++++++++++++
 tb/tb_alu_pipe.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, FSM states and the
// status-flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier. The first partial product is taken
// on the start edge, so the full product appears WIDTH-1 cycles later (done_o).
module alu_mul_iter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q,   busy_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] acc_next;

  assign a_ext    = {{WIDTH{1'b0}}, a_i};
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // The last step's sum is presented combinationally so the caller can
  // register it on the same edge that retires the final partial product.
  assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product_o = acc_next;

  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise paths
    // that do not assign it would infer a latch.
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(1);
      acc_d    = b_i[0] ? a_ext : '0;
      mcand_d  = a_ext << 1;
      mplier_d = b_i >> 1;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done_o) busy_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Single-request ALU with valid/ready handshakes: one-cycle ops for
// add/sub/logic/shift, an iterative multiplier for MUL, registered result+flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] opperand_1,
  input  logic [WIDTH-1:0] opperand_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_overflow,
  output logic             flag_negative
);

  state_e state_q, state_d;
  opcode_e op;
  logic accept;

  logic [WIDTH-1:0] res_q, res_d;
  flags_t           flags_q, flags_d;

  logic [WIDTH:0]   add_full, sub_full;
  logic             shift_oob;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   mul_res;

  assign op        = opcode_e'(opcode);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (opperand_1),
    .b_i       (opperand_2),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign add_full  = {1'b0, opperand_1} + {1'b0, opperand_2};
  assign sub_full  = {1'b0, opperand_1} - {1'b0, opperand_2};
  assign shift_oob = 33'(opperand_2) >= 33'(WIDTH);
  assign mul_res   = mul_product[WIDTH-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (opperand_1[WIDTH-1] == opperand_2[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != opperand_1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (opperand_1[WIDTH-1] != opperand_2[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != opperand_1[WIDTH-1]);
      end
      OP_AND:  alu_res = opperand_1 & opperand_2;
      OP_OR:   alu_res = opperand_1 | opperand_2;
      OP_XOR:  alu_res = opperand_1 ^ opperand_2;
      OP_SHL:  alu_res = shift_oob ? '0 : (opperand_1 << opperand_2);
      OP_SHR:  alu_res = shift_oob ? '0 : (opperand_1 >> opperand_2);
      default: ;
    endcase
  end

  // Result/flags load only on a non-MUL accept or the multiplier's last step.
  always_comb begin
    res_d   = res_q;
    flags_d = flags_q;
    if (accept && (op != OP_MUL)) begin
      res_d            = alu_res;
      flags_d.zero     = (alu_res == '0);
      flags_d.carry    = alu_c;
      flags_d.overflow = alu_v;
      flags_d.negative = alu_res[WIDTH-1];
    end else if (mul_done) begin
      res_d            = mul_res;
      flags_d.zero     = (mul_res == '0);
      flags_d.carry    = |mul_product[2*WIDTH-1:WIDTH];
      flags_d.overflow = 1'b0;
      flags_d.negative = mul_res[WIDTH-1];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (op == OP_MUL) ? ST_CALC : ST_HOLD;
      ST_CALC: if (mul_done) state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign alu_out       = res_q;
  assign flag_zero     = flags_q.zero;
  assign flag_carry    = flags_q.carry;
  assign flag_overflow = flags_q.overflow;
  assign flag_negative = flags_q.negative;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=4): directed vector table, reset
// abort sequence, and random ops against an integer-arithmetic model.
module tb_alu_pipe;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   opcode = '0;
  logic [W-1:0] opperand_1 = '0;
  logic [W-1:0] opperand_2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] alu_out;
  logic         flag_zero, flag_carry, flag_overflow, flag_negative;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .opperand_1    (opperand_1),
    .opperand_2    (opperand_2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_out       (alu_out),
    .flag_zero     (flag_zero),
    .flag_carry    (flag_carry),
    .flag_overflow (flag_overflow),
    .flag_negative (flag_negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flags;  // {zero, carry, overflow, negative}
    int           hold;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [3:0] dut_flags();
    return {flag_zero, flag_carry, flag_overflow, flag_negative};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {result, z, c, v, n}.
  function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int ia = int'(a);
    int ib = int'(b);
    int sa = (ia >= M / 2) ? ia - M : ia;
    int sb = (ib >= M / 2) ? ib - M : ib;
    int full = 0, r = 0, s = 0;
    logic c = 1'b0, v = 1'b0;
    case (op)
      3'd0: begin full = ia + ib; r = full % M; c = (full >= M);
                  s = sa + sb; v = (s > M / 2 - 1) || (s < -M / 2); end
      3'd1: begin r = (ia - ib + M) % M; c = (ia < ib);
                  s = sa - sb; v = (s > M / 2 - 1) || (s < -M / 2); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = (ib >= W) ? 0 : (ia * (1 << ib)) % M;
      3'd6: r = (ib >= W) ? 0 : ia / (1 << ib);
      default: begin full = ia * ib; r = full % M; c = (full >= M); end
    endcase
    return {W'(r), (r == 0), c, v, (r >= M / 2)};
  endfunction

  // One full transaction: accept, latency, result, optional backpressure, release.
  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er,
                        input logic [3:0] ef, input int hold);
    int lat;
    int exp_lat = (op == 3'b111) ? W : 1;
    @(negedge clk);
    check($sformatf("%s in_ready_before", name), in_ready, 1);
    in_valid   = 1'b1;
    opcode     = op;
    opperand_1 = a;
    opperand_2 = b;
    out_ready  = 1'b0;
    @(posedge clk);
    #1;
    opcode     = 3'($urandom);
    opperand_1 = W'($urandom);
    opperand_2 = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check($sformatf("%s in_ready_busy", name), in_ready, 0);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      lat++;
    end
    out_ready = 1'b0;
    check($sformatf("%s latency", name), lat, exp_lat);
    check($sformatf("%s alu_out", name), alu_out, er);
    check($sformatf("%s flags", name), dut_flags(), ef);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s hold_valid", name), out_valid, 1);
      check($sformatf("%s hold_ready", name), in_ready, 0);
      check($sformatf("%s hold_out", name), alu_out, er);
      check($sformatf("%s hold_flags", name), dut_flags(), ef);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check($sformatf("%s released_ready", name), in_ready, 1);
    check($sformatf("%s released_valid", name), out_valid, 0);
  endtask

  initial begin
    logic [W+3:0] m;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    //           op      a        b        res      zcvn     hold
    vecs[0]  = '{3'd0, 4'b0011, 4'b0001, 4'b0100, 4'b0000, 3};
    vecs[1]  = '{3'd1, 4'b0001, 4'b0011, 4'b1110, 4'b0101, 0};
    vecs[2]  = '{3'd0, 4'b0111, 4'b0001, 4'b1000, 4'b0011, 0};
    vecs[3]  = '{3'd7, 4'b0101, 4'b0011, 4'b1111, 4'b0001, 1};
    vecs[4]  = '{3'd7, 4'b0111, 4'b0101, 4'b0011, 4'b0100, 0};
    vecs[5]  = '{3'd5, 4'b0011, 4'b0010, 4'b1100, 4'b0001, 0};
    vecs[6]  = '{3'd6, 4'b1000, 4'b0101, 4'b0000, 4'b1000, 0};
    vecs[7]  = '{3'd2, 4'b1100, 4'b1010, 4'b1000, 4'b0001, 0};
    vecs[8]  = '{3'd3, 4'b0101, 4'b0010, 4'b0111, 4'b0000, 0};
    vecs[9]  = '{3'd4, 4'b1111, 4'b1111, 4'b0000, 4'b1000, 0};
    vecs[10] = '{3'd1, 4'b1000, 4'b0001, 4'b0111, 4'b0010, 0};
    vecs[11] = '{3'd0, 4'b1111, 4'b0001, 4'b0000, 4'b1100, 0};
    vecs[12] = '{3'd5, 4'b0001, 4'b0100, 4'b0000, 4'b1000, 0};
    vecs[13] = '{3'd7, 4'b1111, 4'b1111, 4'b0001, 4'b0100, 2};

    #2;
    check("reset out_valid", out_valid, 0);
    check("reset alu_out", alu_out, 0);
    check("reset flags", dut_flags(), 0);
    check("reset in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].flags, vecs[i].hold);

    // Reset in the second CALC cycle aborts the multiply.
    @(negedge clk);
    in_valid   = 1'b1;
    opcode     = 3'd7;
    opperand_1 = 4'b0111;
    opperand_2 = 4'b0101;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("abort calc in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort alu_out", alu_out, 0);
    check("abort flags", dut_flags(), 0);
    check("abort in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk);
      #1;
      check("abort never presented", out_valid, 0);
    end
    run_op("post_abort add", 3'd0, 4'b0010, 4'b0010, 4'b0100, 4'b0000, 0);

    for (int n = 0; n < 150; n++) begin
      rop = 3'($urandom);
      ra  = W'($urandom);
      rb  = W'($urandom);
      m   = model(rop, ra, rb);
      run_op($sformatf("rand%0d op%0d a%0h b%0h", n, rop, ra, rb), rop, ra, rb,
             m[W+3:4], m[3:0], int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
